// File: rtl/upsp_lane_scheduler.sv
// Frame sequencer: splits each source row into N_PARALLEL equal segments, steers
// segment k to PE lane k, checks row framing and pulses done once lanes drain.
module upsp_lane_scheduler #(
    parameter int unsigned N_PARALLEL     = 4,
    parameter int unsigned DATA_WIDTH     = 24,
    parameter int unsigned SRC_IMG_WIDTH  = 960,
    parameter int unsigned SRC_IMG_HEIGHT = 540
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  s_valid,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    input  logic                                  s_last,
    output logic                                  s_ready,
    output logic [N_PARALLEL-1:0]                 lane_valid,
    output logic [DATA_WIDTH-1:0]                 lane_data,
    input  logic [N_PARALLEL-1:0]                 lane_ready,
    input  logic [N_PARALLEL-1:0]                 lane_busy,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  frame_err,
    output logic [$clog2(SRC_IMG_HEIGHT+1)-1:0]   row_cnt
);

    localparam int unsigned SEG_W  = SRC_IMG_WIDTH / N_PARALLEL;
    localparam int unsigned COL_W  = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
    localparam int unsigned SEG_CW = (SEG_W > 1) ? $clog2(SEG_W) : 1;
    localparam int unsigned LANE_W = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
    localparam int unsigned ROW_W  = $clog2(SRC_IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
    localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(SEG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SEG_CW-1:0]   seg_cnt_q, seg_cnt_d;
    logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                data_en_q;
    logic                run_c;
    logic                xfer_c;
    logic                col_last_c;

    // Zero-latency dispatch: the selected lane's ready gates the stream.
    assign run_c      = (state_q == ST_RUN);
    assign col_last_c = (col_q == COL_LAST);
    assign s_ready    = run_c & lane_ready[lane_sel_q];
    assign xfer_c     = s_valid & s_ready;
    assign lane_valid = (run_c && s_valid) ? (N_PARALLEL'(1) << lane_sel_q) : '0;
    assign lane_data  = data_en_q ? s_data : '0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign row_cnt   = row_cnt_q;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        seg_cnt_d   = seg_cnt_q;
        lane_sel_d  = lane_sel_q;
        row_cnt_d   = row_cnt_q;
        frame_err_d = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    col_d       = '0;
                    seg_cnt_d   = '0;
                    lane_sel_d  = '0;
                    row_cnt_d   = '0;
                    frame_err_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (xfer_c) begin
                    // s_last must coincide with the last column; counters never follow s_last.
                    if (s_last != col_last_c) begin
                        frame_err_d = 1'b1;
                    end
                    if (col_last_c) begin
                        col_d      = '0;
                        seg_cnt_d  = '0;
                        lane_sel_d = '0;
                        row_cnt_d  = row_cnt_q + ROW_W'(1);
                        if (row_cnt_q == ROW_LAST) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                        if (seg_cnt_q == SEG_LAST) begin
                            seg_cnt_d  = '0;
                            lane_sel_d = lane_sel_q + LANE_W'(1);
                        end else begin
                            seg_cnt_d = seg_cnt_q + SEG_CW'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (lane_busy == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (N_PARALLEL == 1) begin
            lane_sel_d = '0;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            seg_cnt_q   <= '0;
            lane_sel_q  <= '0;
            row_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            seg_cnt_q   <= seg_cnt_d;
            lane_sel_q  <= lane_sel_d;
            row_cnt_q   <= row_cnt_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_upsp_lane_scheduler.sv
// Bench for upsp_lane_scheduler: pixel-count model checked every cycle, plus directed literals.
module tb_upsp_lane_scheduler;

    localparam int unsigned NP   = 4;
    localparam int unsigned DW   = 24;
    localparam int unsigned W    = 8;
    localparam int unsigned H    = 2;
    localparam int unsigned SEG  = W / NP;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned RW   = $clog2(H + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = 24'hABCDEF;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [NP-1:0] lane_valid;
    logic [DW-1:0] lane_data;
    logic [NP-1:0] lane_ready = 4'hF;
    logic [NP-1:0] lane_busy = 4'h0;
    logic          busy;
    logic          done;
    logic          frame_err;
    logic [RW-1:0] row_cnt;

    upsp_lane_scheduler #(
        .N_PARALLEL(NP), .DATA_WIDTH(DW), .SRC_IMG_WIDTH(W), .SRC_IMG_HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .lane_valid(lane_valid), .lane_data(lane_data),
        .lane_ready(lane_ready), .lane_busy(lane_busy), .busy(busy), .done(done),
        .frame_err(frame_err), .row_cnt(row_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 run, 2 drain, 3 done; progress is the accepted-pixel count.
    int   m_phase = 0;
    int   m_pix = 0;
    logic m_err = 1'b0;

    function automatic int lane_of(input int p);
        return (p % W) / SEG;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_pix   <= 0;
            m_err   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_pix   <= 0;
                    m_err   <= 1'b0;
                end
                1: if (s_valid && lane_ready[lane_of(m_pix)]) begin
                    if (s_last != ((m_pix % W) == W - 1)) m_err <= 1'b1;
                    m_pix <= m_pix + 1;
                    if (m_pix + 1 == NPIX) m_phase <= 2;
                end
                2: if (lane_busy == '0) m_phase <= 3;
                default: m_phase <= 0;
            endcase
        end
    end

    logic [NP-1:0] exp_lv;
    logic          exp_rdy;

    always @(negedge clk) begin
        exp_rdy = (m_phase == 1) ? lane_ready[lane_of(m_pix)] : 1'b0;
        exp_lv  = (m_phase == 1 && s_valid) ? NP'(1 << lane_of(m_pix)) : '0;
        chk("m_s_ready",    32'(s_ready),    32'(exp_rdy));
        chk("m_lane_valid", 32'(lane_valid), 32'(exp_lv));
        chk("m_busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
        chk("m_done",       32'(done),       32'(m_phase == 3));
        chk("m_frame_err",  32'(frame_err),  32'(m_err));
        chk("m_row_cnt",    32'(row_cnt),    32'(m_pix / W));
        if (rst) chk("m_lane_data_rst", 32'(lane_data), 32'h0);
        else if (m_phase == 1 && s_valid) chk("m_lane_data", 32'(lane_data), 32'(s_data));
        if (done) done_pulses++;
    end

    logic [NP-1:0] pat [W] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b1000, 4'b1000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int idx, input logic last, output logic [NP-1:0] lv);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        lv = '0;
        s_valid = 1'b1;
        s_data = DW'(idx);
        s_last = last;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_ready;
            lv = lane_valid;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk($sformatf("send_timeout_px%0d", idx), 32'(acc), 32'h1);
    endtask

    task automatic stream(input int from, input int to, input int bad_last);
        logic [NP-1:0] lv;
        for (int i = from; i <= to; i++) begin
            send(i, ((i % W) == W - 1) || (i == bad_last), lv);
            chk($sformatf("lane_valid_px%0d", i), 32'(lv), 32'(pat[i % W]));
            if ((i % W) == W - 1) chk($sformatf("row_cnt_px%0d", i), 32'(row_cnt), 32'((i + 1) / W));
        end
    endtask

    task automatic stop_stream();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done(input int exp_n);
        int n;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk("done_latency", 32'(n), 32'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before t=100000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s_ready",    32'(s_ready),    32'h0);
        chk("rst_lane_valid", 32'(lane_valid), 32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_done",       32'(done),       32'h0);
        chk("rst_frame_err",  32'(frame_err),  32'h0);
        chk("rst_row_cnt",    32'(row_cnt),    32'h0);
        chk("rst_lane_data",  32'(lane_data),  32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Back-pressure free frame
        do_start();
        stream(0, 15, -1);
        stop_stream();
        wait_done(2);
        chk("t1_row_cnt", 32'(row_cnt), 32'h2);
        chk("t1_frame_err", 32'(frame_err), 32'h0);
        tick();
        repeat (3) tick();
        chk("t1_done_pulses", 32'(done_pulses), 32'h1);

        // Lane 2 stall on pixel 4, then drain hold on lane 1
        do_start();
        stream(0, 3, -1);
        lane_ready = 4'b1011;
        s_valid = 1'b1;
        s_data = DW'(4);
        s_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_s_ready",    32'(s_ready),    32'h0);
            chk("stall_lane_valid", 32'(lane_valid), 32'h4);
            chk("stall_lane_data",  32'(lane_data),  32'h4);
        end
        @(posedge clk);
        #1;
        lane_ready = 4'hF;
        @(negedge clk);
        chk("stall_release_ready", 32'(s_ready), 32'h1);
        tick();
        stream(5, 14, -1);
        lane_busy = 4'b0010;
        stream(15, 15, -1);
        stop_stream();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("drain_busy", 32'(busy), 32'h1);
            chk("drain_done", 32'(done), 32'h0);
        end
        tick();
        lane_busy = 4'h0;
        @(negedge clk);
        chk("drain_last_busy", 32'(busy), 32'h1);
        chk("drain_last_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("drain_done_pulse", 32'(done), 32'h1);
        chk("drain_done_busy",  32'(busy), 32'h0);
        @(negedge clk);
        chk("drain_after_done", 32'(done), 32'h0);
        tick();

        // Framing error via early s_last on pixel 5
        do_start();
        stream(0, 4, 5);
        chk("ferr_before", 32'(frame_err), 32'h0);
        stream(5, 5, 5);
        chk("ferr_set", 32'(frame_err), 32'h1);
        stream(6, 15, 5);
        stop_stream();
        wait_done(2);
        chk("ferr_sticky", 32'(frame_err), 32'h1);
        tick();
        repeat (2) tick();
        chk("ferr_idle_sticky", 32'(frame_err), 32'h1);
        do_start();
        chk("ferr_cleared", 32'(frame_err), 32'h0);

        // Reset after pixel 9
        stream(0, 9, -1);
        rst = 1'b1;
        #1;
        chk("mrst_s_ready",    32'(s_ready),    32'h0);
        chk("mrst_lane_valid", 32'(lane_valid), 32'h0);
        chk("mrst_lane_data",  32'(lane_data),  32'h0);
        chk("mrst_busy",       32'(busy),       32'h0);
        chk("mrst_row_cnt",    32'(row_cnt),    32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        stop_stream();
        tick();
        do_start();
        stream(0, 15, -1);
        stop_stream();
        wait_done(2);
        chk("mrst_row_cnt_end", 32'(row_cnt), 32'h2);
        tick();

        // Spurious start while running
        do_start();
        stream(0, 2, -1);
        start = 1'b1;
        stream(3, 3, -1);
        start = 1'b0;
        chk("spur_row_cnt", 32'(row_cnt), 32'h0);
        chk("spur_busy", 32'(busy), 32'h1);
        stream(4, 15, -1);
        stop_stream();
        wait_done(2);
        chk("spur_row_cnt_end", 32'(row_cnt), 32'h2);
        repeat (3) tick();
        chk("total_done_pulses", 32'(done_pulses), 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
